// File: rtl/mul_shift_add32_if.sv
// Control-side bus of the shift-add multiplier: start/operands in, busy/done/product out.
// Optional macro SIGNED_MUL_EN adds the sgn request bit.
interface mul_shift_add32_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
`ifdef SIGNED_MUL_EN
  logic               sgn;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  // ALU control side
  modport master (
`ifdef SIGNED_MUL_EN
    output sgn,
`endif
    output start, op_a, op_b,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
`ifdef SIGNED_MUL_EN
    input  sgn,
`endif
    input  start, op_a, op_b,
    output busy, done, product
  );
endinterface

// File: rtl/mul_shift_add32.sv
// Iterative radix-2 shift-add 32x32->64 multiplier driving an external
// combinational adder (add_x/add_y out, add_s/add_c back) once per cycle.
// Optional macro SIGNED_MUL_EN: two's-complement mode via sgn, with a
// one-cycle FIX state that negates the product when operand signs differ.
module mul_shift_add32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  mul_shift_add32_if.slave bus,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
`ifdef SIGNED_MUL_EN
    , S_FIX = 2'd3
`endif
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   load_a, load_b;
  logic               fix_req;
  logic               last_iter;

`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d, neg_load;

  // Operand magnitudes use a private negate so the shared adder stays free.
  assign load_a   = (bus.sgn && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
  assign load_b   = (bus.sgn && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
  assign neg_load = bus.sgn && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
  assign fix_req  = neg_q;
`else
  assign load_a  = bus.op_a;
  assign load_b  = bus.op_b;
  assign fix_req = 1'b0;
`endif

  assign last_iter = (cnt_q == '1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_CALC;
      S_CALC: begin
        if (last_iter) begin
`ifdef SIGNED_MUL_EN
          state_d = fix_req ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SIGNED_MUL_EN
      S_FIX:  state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: status flags and adder operands (zero outside CALC)
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
    add_x    = '0;
    add_y    = '0;
    if (state_q == S_CALC) begin
      add_x = acc_q;
      add_y = mq_q[0] ? mcand_q : '0;
    end
  end

  // Datapath next values: operand load, shift-add step, final product capture
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SIGNED_MUL_EN
    neg_d     = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d   = load_a;
          mq_d      = load_b;
          acc_d     = '0;
          cnt_d     = '0;
          product_d = '0;
`ifdef SIGNED_MUL_EN
          neg_d     = neg_load;
`endif
        end
      end
      S_CALC: begin
        acc_d = {add_c, add_s[WIDTH-1:1]};
        mq_d  = {add_s[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        // Product is captured on the way into DONE so it is valid with done.
        if (last_iter && !fix_req) product_d = {acc_d, mq_d};
      end
`ifdef SIGNED_MUL_EN
      S_FIX:  product_d = ~{acc_q, mq_q} + (2*WIDTH)'(1);
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SIGNED_MUL_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SIGNED_MUL_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_mul_shift_add32.sv
module tb_mul_shift_add32;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] add_x, add_y, add_s;
  logic        add_c;
  logic        sgn_s;

  mul_shift_add32_if #(.WIDTH(32)) bus ();

  mul_shift_add32 #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .add_x (add_x),
    .add_y (add_y),
    .add_s (add_s),
    .add_c (add_c)
  );

`ifdef SIGNED_MUL_EN
  assign bus.sgn = sgn_s;
`endif

  // Combinational 32-bit adder stand-in
  assign {add_c, add_s} = {1'b0, add_x} + {1'b0, add_y};

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Hand-computed expectations attached to the next accepted operation
  logic [63:0] lit_exp;
  int          lit_lat;

  // Transaction-level model
  int              left = 0;
  longint unsigned cyc = 0;
  longint unsigned acc_cyc = 0;
  logic [63:0]     exp_prod = '0;
  logic [63:0]     pend_prod = '0;
  logic [63:0]     pend_lit = '0;
  int              pend_lat = 0;
  logic [31:0]     cur_mag_a = '0;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] a, input logic s);
    if (s && a[31]) return 32'd0 - a;
    return a;
  endfunction

  // Model: busy spans 33 cycles (34 with a sign fix) after the accept edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      left     <= 0;
      exp_prod <= '0;
    end else if (left == 0) begin
      if (bus.start) begin
        left      <= (sgn_s && (bus.op_a[31] ^ bus.op_b[31])) ? 34 : 33;
        exp_prod  <= '0;
        pend_prod <= ref_mul(bus.op_a, bus.op_b, sgn_s);
        pend_lit  <= lit_exp;
        pend_lat  <= lit_lat;
        acc_cyc   <= cyc + 1;
        cur_mag_a <= mag(bus.op_a, sgn_s);
      end
    end else begin
      left <= left - 1;
      if (left == 2) exp_prod <= pend_prod;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(left > 0));
      check("done", 64'(bus.done), 64'(left == 1));
      check("product", bus.product, exp_prod);
      if (left == 0 || left == 1) begin
        check("add_x_idle", 64'(add_x), 64'd0);
        check("add_y_idle", 64'(add_y), 64'd0);
      end else begin
        check("add_y_operand", 64'(add_y == 32'd0 || add_y == cur_mag_a), 64'd1);
      end
      if (left == 1) begin
        check("lit_product", bus.product, pend_lit);
        check("lit_latency", 64'(cyc - acc_cyc), 64'(pend_lat));
      end
    end
  end

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] lit, input int lat);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    sgn_s     = s;
    lit_exp   = lit;
    lit_lat   = lat;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    sgn_s     = 1'b0;
    lit_exp   = '0;
    lit_lat   = 32;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic product and latency
    drive_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 32);
    repeat (36) @(negedge clk);

    // Carry out captured on every iteration
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 32);
    repeat (36) @(negedge clk);

    drive_op(32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 32);
    repeat (36) @(negedge clk);

    drive_op(32'd0, 32'hFFFF_FFFF, 1'b0, 64'd0, 32);
    repeat (36) @(negedge clk);

    // op_b = 0, then start held through done: second op at first IDLE edge
    @(negedge clk);
    bus.op_a  = 32'h1234_5678;
    bus.op_b  = 32'd0;
    lit_exp   = 64'd0;
    lit_lat   = 32;
    bus.start = 1'b1;
    @(negedge clk);
    bus.op_a  = 32'd7;
    bus.op_b  = 32'd9;
    lit_exp   = 64'd63;
    repeat (34) @(negedge clk);
    bus.start = 1'b0;
    repeat (36) @(negedge clk);

    // Start pulses during busy are ignored
    drive_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 32);
    repeat (4) @(negedge clk);
    bus.op_a  = 32'd100;
    bus.op_b  = 32'd200;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    bus.op_a  = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);

    // Reset in mid-calculation aborts without a done pulse
    drive_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 64'd0, 32);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    drive_op(32'd12, 32'd12, 1'b0, 64'd144, 32);
    repeat (36) @(negedge clk);

`ifdef SIGNED_MUL_EN
    drive_op(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    repeat (37) @(negedge clk);
    drive_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 32);
    repeat (36) @(negedge clk);
    drive_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, 64'd42, 32);
    repeat (36) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
